// File: rtl/lsu_wb.sv
// Load/store unit and load writeback source for the nano RV32I core.
// Runs one req/gnt/rvalid data-memory transaction at a time.
module lsu_wb #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              reg_write_o,
  output logic [4:0]        rd_o,
  output logic [31:0]       write_data_o,
  output logic              err_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StWb} state_e;

  state_e            state_q;
  logic              dmem_req_q;
  logic              dmem_we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_pend_q;
  logic              reg_write_q;
  logic [4:0]        rd_q;
  logic [31:0]       result_q;
  logic              err_q;

  logic              illegal;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic [31:0]       lane;
  logic [31:0]       load_data;

  always_comb begin
    if (req_we_i) begin
      illegal = req_funct3_i[2] | (req_funct3_i[1:0] == 2'd3);
    end else begin
      illegal = (req_funct3_i[1:0] == 2'd3) | (req_funct3_i[2] & req_funct3_i[1]);
    end
    if ((req_funct3_i[1:0] == 2'd1) && req_addr_i[0]) illegal = 1'b1;
    if ((req_funct3_i[1:0] == 2'd2) && (req_addr_i[1:0] != 2'b00)) illegal = 1'b1;
  end

  always_comb begin
    unique case (req_funct3_i[1:0])
      2'd0: begin
        be_new    = 4'b0001 << req_addr_i[1:0];
        wdata_new = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        be_new    = 4'b0011 << req_addr_i[1:0];
        wdata_new = {2{req_wdata_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = req_wdata_i;
      end
    endcase
  end

  assign lane = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    unique case (funct3_q)
      3'd0:    load_data = {{24{lane[7]}}, lane[7:0]};
      3'd1:    load_data = {{16{lane[15]}}, lane[15:0]};
      3'd4:    load_data = {24'd0, lane[7:0]};
      3'd5:    load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      be_q        <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      rd_pend_q   <= 5'd0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      result_q    <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= 1'b0;
      reg_write_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            if (illegal) begin
              err_q <= 1'b1;
            end else begin
              state_q    <= StReq;
              dmem_req_q <= 1'b1;
              dmem_we_q  <= req_we_i;
              be_q       <= be_new;
              addr_q     <= {req_addr_i[ADDR_W-1:2], 2'b00};
              wdata_q    <= wdata_new;
              funct3_q   <= req_funct3_i;
              off_q      <= req_addr_i[1:0];
              rd_pend_q  <= req_rd_i;
            end
          end
        end
        StReq: begin
          if (dmem_gnt_i) begin
            dmem_req_q <= 1'b0;
            state_q    <= dmem_we_q ? StIdle : StWait;
          end
        end
        StWait: begin
          if (dmem_rvalid_i) begin
            state_q     <= StWb;
            reg_write_q <= (rd_pend_q != 5'd0);
            rd_q        <= rd_pend_q;
            result_q    <= load_data;
          end
        end
        StWb: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready is gated by reset directly so it reads 0 throughout the reset cycle.
  assign req_ready_o  = (state_q == StIdle) && !rst_i;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_be_o    = be_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign reg_write_o  = reg_write_q;
  assign rd_o         = rd_q;
  assign write_data_o = result_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Bench for lsu_wb: directed and randomized memory ops checked against a
// behavioural model of the load/store rules.
module tb_lsu_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req, dmem_gnt, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        err;

  int total = 0;
  int bad   = 0;

  lsu_wb #(.ADDR_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_rd_i     (req_rd),
    .dmem_req_o   (dmem_req),
    .dmem_gnt_i   (dmem_gnt),
    .dmem_we_o    (dmem_we),
    .dmem_be_o    (dmem_be),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i (dmem_rdata),
    .reg_write_o  (reg_write),
    .rd_o         (rd),
    .write_data_o (write_data),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: legality, byte enables, store data, load result.
  function automatic bit m_legal(input bit we, input bit [2:0] f, input bit [31:0] a);
    int sz = 1 << f[1:0];
    if (we && f >= 3) return 0;
    if (!we && (f == 3 || f == 6 || f == 7)) return 0;
    if (sz == 2 && (a % 2) != 0) return 0;
    if (sz == 4 && (a % 4) != 0) return 0;
    return 1;
  endfunction

  function automatic bit [3:0] m_be(input bit [2:0] f, input bit [31:0] a);
    int bytes = 1 << f[1:0];
    int mask  = ((1 << bytes) - 1) << (a % 4);
    return 4'(mask);
  endfunction

  function automatic bit [31:0] m_wdata(input bit [2:0] f, input bit [31:0] d);
    if (f[1:0] == 0) return (d % 256) * 32'h0101_0101;
    if (f[1:0] == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f, input bit [31:0] a,
                                       input bit [31:0] rdata);
    bit [31:0] v = rdata >> (8 * (a % 4));
    bit [31:0] b = v % 256;
    bit [31:0] h = v % 65536;
    case (f)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return v;
    endcase
  endfunction

  // One op: inputs driven on negedge, outputs sampled on negedge.
  task automatic do_op(input bit we, input bit [2:0] f, input bit [31:0] a,
                       input bit [31:0] d, input bit [4:0] r, input int gnt_dly,
                       input int rv_dly, input bit [31:0] rdata);
    bit legal = m_legal(we, f, a);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_we = we; req_funct3 = f; req_addr = a; req_wdata = d; req_rd = r;
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    req_funct3 = 3'($urandom); req_we = 1'($urandom);
    if (!legal) begin
      chk("err_pulse", 32'(err), 32'd1);
      chk("illegal_noreq", 32'(dmem_req), 32'd0);
      @(negedge clk);
      chk("err_clear", 32'(err), 32'd0);
      chk("illegal_noreq2", 32'(dmem_req), 32'd0);
      chk("illegal_nowb", 32'(reg_write), 32'd0);
      return;
    end
    chk("legal_noerr", 32'(err), 32'd0);
    for (int i = 0; i <= gnt_dly; i++) begin
      chk("req", 32'(dmem_req), 32'd1);
      chk("we", 32'(dmem_we), 32'(we));
      chk("be", 32'(dmem_be), 32'(m_be(f, a)));
      chk("addr", dmem_addr, a & ~32'd3);
      chk("wdata", dmem_wdata, m_wdata(f, d));
      chk("ready_busy", 32'(req_ready), 32'd0);
      if (i == gnt_dly) begin
        dmem_gnt = 1;
        // rvalid coinciding with gnt must be ignored
        dmem_rvalid = 1; dmem_rdata = ~rdata;
      end
      @(negedge clk);
    end
    dmem_gnt = 0; dmem_rvalid = 0;
    chk("req_drop", 32'(dmem_req), 32'd0);
    chk("no_wb_early", 32'(reg_write), 32'd0);
    if (we) begin
      chk("store_ready", 32'(req_ready), 32'd1);
      return;
    end
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge clk);
      chk("wait_nowb", 32'(reg_write), 32'd0);
    end
    dmem_rvalid = 1; dmem_rdata = rdata;
    @(negedge clk);
    dmem_rvalid = 0; dmem_rdata = $urandom;
    chk("wb_strobe", 32'(reg_write), 32'(r != 0));
    chk("wb_rd", 32'(rd), 32'(r));
    chk("wb_data", write_data, m_load(f, a, rdata));
    chk("wb_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("wb_once", 32'(reg_write), 32'd0);
    chk("load_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    req_rd = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wb", 32'(reg_write), 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 0;

    do_op(1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'd0);       // SW
    do_op(1, 3'd0, 32'h103, 32'h000000A5, 5'd0, 1, 0, 32'd0);       // SB
    do_op(0, 3'd0, 32'h102, 32'd0, 5'd5, 0, 0, 32'h12F45678);       // LB
    do_op(0, 3'd4, 32'h102, 32'd0, 5'd5, 0, 0, 32'h12F45678);       // LBU
    do_op(0, 3'd1, 32'h102, 32'd0, 5'd5, 0, 0, 32'h12F45678);       // LH
    do_op(0, 3'd1, 32'h001, 32'd0, 5'd5, 0, 0, 32'd0);              // misaligned LH
    do_op(0, 3'd2, 32'h002, 32'd0, 5'd5, 0, 0, 32'd0);              // misaligned LW
    do_op(0, 3'd3, 32'h000, 32'd0, 5'd5, 0, 0, 32'd0);              // illegal funct3
    do_op(1, 3'd4, 32'h000, 32'd0, 5'd0, 0, 0, 32'd0);              // illegal store
    do_op(0, 3'd2, 32'h40, 32'd0, 5'd7, 3, 1, 32'h0BADF00D);        // slow LW
    do_op(0, 3'd2, 32'h44, 32'd0, 5'd0, 0, 0, 32'h11112222);        // rd=0

    // Reset while waiting for read data; a late rvalid must be dropped.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h80; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 0; dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0; rst = 1;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_wb", 32'(reg_write), 32'd0);
    chk("midrst_idle", 32'(req_ready), 32'd1);
    dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dmem_rvalid = 0;
    chk("late_rvalid", 32'(reg_write), 32'd0);
    @(negedge clk);
    chk("late_rvalid2", 32'(reg_write), 32'd0);

    for (int i = 0; i < 80; i++) begin
      bit [31:0] a = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            5'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
